// File: rtl/vga_timing_driver.sv
// ----------------------------------------------------------------------------
// vga_timing_driver
//
// Raster timing master and DAC-side driver for a 640x480@60 VGA output.
// Publishes the coordinates of the pixel that will be shown after the next
// pixel tick (next_x/next_y), so colour generators have one pixel period to
// produce vga_color. On each tick, that colour is captured, expanded from
// RGB332 to 8 bits per channel, and loaded together with sync/blank.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   vga_color     in   RGB332 {R[7:5],G[4:2],B[1:0]} for pixel (next_x,next_y)
//   next_x        out  column of the pixel shown after the next tick
//   next_y        out  row of that pixel
//   next_visible  out  (next_x,next_y) lies inside the visible area
//   frame_start   out  one-clk pulse after the tick that loads pixel (0,0)
//   vga_r/g/b     out  registered DAC colour, zero outside the visible area
//   vga_hs        out  horizontal sync, active-low
//   vga_vs        out  vertical sync, active-low
//   vga_blank_n   out  high while the displayed pixel is visible
//   vga_sync_n    out  tied low (no sync-on-green)
//   vga_clk       out  registered pixel-rate clock to the DAC
// ----------------------------------------------------------------------------
module vga_timing_driver #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_color,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       next_visible,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             pix_tick;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             hs_next;
    logic             vs_next;
    logic [7:0]       r_exp;
    logic [7:0]       g_exp;
    logic [7:0]       b_exp;

    assign pix_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign vga_sync_n = 1'b0;

    // Successor of the displayed pixel; raw counter values, not clamped
    // during blanking.
    always_comb begin
        h_wrap = (h_cnt == 10'(H_TOTAL - 1));
        next_x = h_wrap ? 10'd0 : h_cnt + 10'd1;
        if (h_wrap)
            next_y = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
        else
            next_y = v_cnt;
    end

    assign next_visible = (next_x < 10'(H_VISIBLE)) && (next_y < 10'(V_VISIBLE));
    assign hs_next = !((next_x >= 10'(HS_START)) && (next_x < 10'(HS_END)));
    assign vs_next = !((next_y >= 10'(VS_START)) && (next_y < 10'(VS_END)));

    // Bit replication maps full-scale 3/2-bit codes onto 8'hFF.
    assign r_exp = {vga_color[7:5], vga_color[7:5], vga_color[7:6]};
    assign g_exp = {vga_color[4:2], vga_color[4:2], vga_color[4:3]};
    assign b_exp = {4{vga_color[1:0]}};

    // Reset parks the counters on the last pixel of the frame so the first
    // tick after release lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            h_cnt       <= 10'(H_TOTAL - 1);
            v_cnt       <= 10'(V_TOTAL - 1);
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_clk     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                div_cnt     <= '0;
                h_cnt       <= next_x;
                v_cnt       <= next_y;
                vga_r       <= next_visible ? r_exp : 8'd0;
                vga_g       <= next_visible ? g_exp : 8'd0;
                vga_b       <= next_visible ? b_exp : 8'd0;
                vga_blank_n <= next_visible;
                vga_hs      <= hs_next;
                vga_vs      <= vs_next;
                vga_clk     <= 1'b0;
                frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                // Rising DAC edge half a pixel after the outputs change.
                if (div_cnt == DIV_W'(CLK_DIV / 2 - 1))
                    vga_clk <= 1'b1;
            end
        end
    end

endmodule
